// File: rtl/amm_burst_bridge.sv
// amm_burst_bridge: bursting Avalon-MM slave to single-beat master; define AMM_BURST_BRIDGE_WRAP_EN for wrapping bursts
module amm_burst_bridge #(
  parameter int P_ASIZE  = 32,
  parameter int P_DBYTES = 4,
  parameter int P_BSIZE  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [P_ASIZE-1:0]    s_address,
  input  logic [P_BSIZE-1:0]    s_burstcount,
  input  logic                  s_read,
  input  logic                  s_write,
  input  logic [P_DBYTES*8-1:0] s_writedata,
  input  logic [P_DBYTES-1:0]   s_byteenable,
  output logic                  s_waitrequest,
  output logic [P_DBYTES*8-1:0] s_readdata,
  output logic                  s_readdatavalid,
  output logic [P_ASIZE-1:0]    m_address,
  output logic [P_DBYTES*8-1:0] m_writedata,
  output logic [P_DBYTES-1:0]   m_byteenable,
  output logic                  m_read,
  output logic                  m_write,
  input  logic                  m_waitrequest,
  input  logic [P_DBYTES*8-1:0] m_readdata
);
  localparam logic [P_BSIZE-1:0] ONE  = P_BSIZE'(1);
  localparam logic [P_ASIZE-1:0] STEP = P_ASIZE'(P_DBYTES);
`ifdef AMM_BURST_BRIDGE_WRAP_EN
  localparam int P_MAXB = 1 << (P_BSIZE - 1);
  localparam logic [P_ASIZE-1:0] WMASK = P_ASIZE'(P_MAXB * P_DBYTES - 1);
`endif
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t state;
  logic [P_ASIZE-1:0] base;
  logic [P_BSIZE-1:0] cnt, i_beat, acc_cnt, bc;
  logic hv, last, up_acc, dn_acc;
  function automatic logic [P_ASIZE-1:0] baddr(input logic [P_ASIZE-1:0] b, input logic [P_BSIZE-1:0] k);
    logic [P_ASIZE-1:0] n;
    n = b + P_ASIZE'(k) * STEP;
`ifdef AMM_BURST_BRIDGE_WRAP_EN
    return (b & ~WMASK) | (n & WMASK);
`else
    return n;
`endif
  endfunction
  always_comb begin
    bc = (s_burstcount == '0) ? ONE : s_burstcount;
    last = (i_beat == cnt - ONE);
    s_waitrequest = (state == RD) | ((state == WR) & ((acc_cnt == '0) | (hv & m_waitrequest)));
    up_acc = (state == WR) & s_write & ~s_waitrequest;
    dn_acc = hv & ~m_waitrequest;
  end
  assign m_write = hv;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      base            <= '0;
      cnt             <= '0;
      i_beat          <= '0;
      acc_cnt         <= '0;
      hv              <= 1'b0;
      s_readdata      <= '0;
      s_readdatavalid <= 1'b0;
      m_address       <= '0;
      m_writedata     <= '0;
      m_byteenable    <= '0;
      m_read          <= 1'b0;
    end else begin
      s_readdatavalid <= 1'b0;
      case (state)
        IDLE: begin
          if (s_write) begin
            state        <= WR;
            base         <= s_address;
            cnt          <= bc;
            acc_cnt      <= bc - ONE;
            i_beat       <= '0;
            m_address    <= s_address;
            m_writedata  <= s_writedata;
            m_byteenable <= s_byteenable;
            hv           <= 1'b1;
          end else if (s_read) begin
            state        <= RD;
            base         <= s_address;
            cnt          <= bc;
            i_beat       <= '0;
            m_address    <= s_address;
            m_byteenable <= '1;
            m_read       <= 1'b1;
          end
        end
        RD: begin
          if (!m_waitrequest) begin
            s_readdata      <= m_readdata;
            s_readdatavalid <= 1'b1;
            if (last) begin
              state  <= IDLE;
              m_read <= 1'b0;
            end else begin
              i_beat    <= i_beat + ONE;
              m_address <= baddr(base, i_beat + ONE);
            end
          end
        end
        WR: begin
          // a refill in the same cycle as a drain keeps hv set, so no bubble
          if (up_acc) begin
            m_writedata  <= s_writedata;
            m_byteenable <= s_byteenable;
            hv           <= 1'b1;
            acc_cnt      <= acc_cnt - ONE;
          end else if (dn_acc) begin
            hv <= 1'b0;
          end
          if (dn_acc) begin
            if (last) begin
              state <= IDLE;
            end else begin
              i_beat    <= i_beat + ONE;
              m_address <= baddr(base, i_beat + ONE);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  a_rd_wr_excl: assert property (@(posedge clk) disable iff (!rst_n) !((state == IDLE) && s_read && s_write));
endmodule

// File: tb/tb_amm_burst_bridge.sv
// tb_amm_burst_bridge: directed and randomized bursts checked against a transaction-level model
module tb_amm_burst_bridge;
  logic        clk, rst_n;
  logic [31:0] s_address;
  logic [3:0]  s_burstcount;
  logic        s_read, s_write;
  logic [31:0] s_writedata;
  logic [3:0]  s_byteenable;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic        s_readdatavalid;
  logic [31:0] m_address, m_writedata;
  logic [3:0]  m_byteenable;
  logic        m_read, m_write, m_waitrequest;
  logic [31:0] m_readdata;
  int n_chk = 0;
  int n_fail = 0;

  amm_burst_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .s_address(s_address), .s_burstcount(s_burstcount), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .m_address(m_address), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_read(m_read), .m_write(m_write), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction
  assign m_readdata = mem_data(m_address);

  // beat k of a burst: 4-byte steps, 32-byte window when wrapping
  function automatic logic [31:0] exp_addr(input logic [31:0] b, input int k);
`ifdef AMM_BURST_BRIDGE_WRAP_EN
    return b - (b % 32) + ((b + 32'(k * 4)) % 32);
`else
    return b + 32'(k * 4);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] b, input int bc, input int st_pct, input int st_beat, input int st_len);
    int n, k, stl, cyc;
    logic pv;
    logic [31:0] pa;
    n = (bc == 0) ? 1 : bc;
    k = 0; stl = 0; cyc = 0; pv = 1'b0; pa = '0;
    s_read = 1'b1; s_address = b; s_burstcount = 4'(bc); m_waitrequest = 1'b0;
    @(negedge clk);
    chk("rd_cmd_wait", 32'(s_waitrequest), 0);
    @(posedge clk); #1;
    s_read = 1'b0; s_address = $urandom; s_burstcount = 4'($urandom);
    while (k < n && cyc < 200) begin
      m_waitrequest = (k == st_beat && stl < st_len) || ($urandom_range(99) < st_pct);
      if (k == st_beat && stl < st_len) stl++;
      @(negedge clk);
      chk("rd_m_read", 32'(m_read), 1);
      chk("rd_addr", m_address, exp_addr(b, k));
      chk("rd_be", 32'(m_byteenable), 32'hF);
      chk("rd_swait", 32'(s_waitrequest), 1);
      chk("rd_valid", 32'(s_readdatavalid), 32'(pv));
      if (pv) chk("rd_data", s_readdata, mem_data(pa));
      pv = !m_waitrequest;
      if (pv) begin
        pa = exp_addr(b, k);
        k++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    m_waitrequest = 1'b0;
    @(negedge clk);
    chk("rd_done", 32'(k), 32'(n));
    chk("rd_valid_last", 32'(s_readdatavalid), 1);
    chk("rd_data_last", s_readdata, mem_data(pa));
    chk("rd_m_read_end", 32'(m_read), 0);
    chk("rd_idle_swait", 32'(s_waitrequest), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] b, input int bc, input int st_pct, input int gap_beat, input int gap_pct);
    int n, up, dn, held, cyc;
    logic exp_sw, gap_done, gap_now;
    logic [31:0] wd[$];
    logic [3:0]  wb[$];
    n = (bc == 0) ? 1 : bc;
    for (int k = 0; k < n; k++) begin
      wd.push_back($urandom);
      wb.push_back(4'($urandom));
    end
    s_write = 1'b1; s_address = b; s_burstcount = 4'(bc);
    s_writedata = wd[0]; s_byteenable = wb[0]; m_waitrequest = 1'b0;
    @(negedge clk);
    chk("wr_cmd_wait", 32'(s_waitrequest), 0);
    chk("wr_m_write_idle", 32'(m_write), 0);
    @(posedge clk); #1;
    up = 1; held = 1; dn = 0; cyc = 0; gap_done = 1'b0;
    s_address = $urandom; s_burstcount = 4'($urandom);
    while (dn < n && cyc < 300) begin
      gap_now = (up == gap_beat) && !gap_done;
      if (gap_now) gap_done = 1'b1;
      s_write = (up < n) && !gap_now && ($urandom_range(99) >= gap_pct);
      s_writedata = (up < n) ? wd[up] : $urandom;
      s_byteenable = (up < n) ? wb[up] : 4'($urandom);
      m_waitrequest = $urandom_range(99) < st_pct;
      @(negedge clk);
      chk("wr_m_write", 32'(m_write), 32'(held > 0));
      exp_sw = (up == n) || (held > 0 && m_waitrequest);
      chk("wr_swait", 32'(s_waitrequest), 32'(exp_sw));
      if (held > 0 && !m_waitrequest) begin
        chk("wr_addr", m_address, exp_addr(b, dn));
        chk("wr_data", m_writedata, wd[dn]);
        chk("wr_be", 32'(m_byteenable), 32'(wb[dn]));
        dn++;
        held--;
      end
      if (s_write && !exp_sw) begin
        up++;
        held++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    s_write = 1'b0; m_waitrequest = 1'b0;
    @(negedge clk);
    chk("wr_done", 32'(dn), 32'(n));
    chk("wr_idle_swait", 32'(s_waitrequest), 0);
    chk("wr_m_write_end", 32'(m_write), 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_swait"}, 32'(s_waitrequest), 0);
    chk({tag, "_rdv"}, 32'(s_readdatavalid), 0);
    chk({tag, "_rdata"}, s_readdata, 0);
    chk({tag, "_mread"}, 32'(m_read), 0);
    chk({tag, "_mwrite"}, 32'(m_write), 0);
    chk({tag, "_maddr"}, m_address, 0);
    chk({tag, "_mwdata"}, m_writedata, 0);
    chk({tag, "_mbe"}, 32'(m_byteenable), 0);
  endtask

  initial begin
    rst_n = 1'b0; s_address = '0; s_burstcount = '0; s_read = 1'b0; s_write = 1'b0;
    s_writedata = '0; s_byteenable = '0; m_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_read(32'h100, 4, 0, -1, 0);
    do_read(32'h0, 3, 0, 1, 2);
    do_write(32'hFFFF_FFF8, 4, 0, 2, 0);
    do_read(32'h38, 8, 0, -1, 0);
    do_write(32'h38, 8, 0, -1, 0);
    do_read(32'h40, 0, 0, -1, 0);
    do_write(32'h80, 0, 0, -1, 0);
    // reset in the middle of a 4-beat read, while beat 2 is presented
    s_read = 1'b1; s_address = 32'h200; s_burstcount = 4'd4; m_waitrequest = 1'b0;
    @(posedge clk); #1;
    s_read = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_addr_beat2", m_address, exp_addr(32'h200, 2));
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_rdv", 32'(s_readdatavalid), 0);
      chk("post_rst_mread", 32'(m_read), 0);
      @(posedge clk); #1;
    end
    do_read(32'h300, 4, 0, -1, 0);
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(1) == 1)
        do_read({$urandom_range(32'hFFFF_FFFF, 0) >> 2, 2'b00}, $urandom_range(8), 30, -1, 0);
      else
        do_write({$urandom_range(32'hFFFF_FFFF, 0) >> 2, 2'b00}, $urandom_range(8), 30, -1, 30);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
